// File: rtl/ddr2_blk_rdwr_gearbox.sv
// Byte-granular IN_BYTES -> OUT_BYTES width converter (MSB-first) with input/output
// fallthrough FIFOs and a zero-padded flush tail. Optional checks: GEARBOX_ERR_CHECK_EN.
module ddr2_blk_rdwr_gearbox #(
    parameter int IN_BYTES   = 8,
    parameter int OUT_BYTES  = 9,
    parameter int DEPTH_BITS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*IN_BYTES-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   full,
    input  logic                   flush,
    output logic                   flush_busy,
    input  logic                   rd_en,
    output logic [8*OUT_BYTES-1:0] rd_data,
    output logic [5:0]             rd_bytes,
    output logic [8*OUT_BYTES-1:0] rd_data_d1,
    output logic                   empty,
    output logic                   err_ovf,
    output logic                   err_udf
);
    localparam int IN_W  = 8 * IN_BYTES;
    localparam int OUT_W = 8 * OUT_BYTES;
    localparam int CAP   = IN_BYTES + OUT_BYTES - 1;
    localparam int CAP_W = 8 * CAP;
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int ENT_W = OUT_W + 6;
    localparam int CW    = DEPTH_BITS + 1;

    localparam logic [6:0]    IN_C    = 7'(IN_BYTES);
    localparam logic [6:0]    OUT_C   = 7'(OUT_BYTES);
    localparam logic [6:0]    CAP_C   = 7'(CAP);
    localparam logic [5:0]    OUT_B6  = 6'(OUT_BYTES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] NFULL_C = CW'(DEPTH - 1);

    logic [IN_W-1:0]       r_in_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_in_wptr, r_in_rptr;
    logic [CW-1:0]         r_in_cnt;
    logic                  w_in_empty, w_in_tfull, w_in_push, w_in_pop;
    logic [IN_W-1:0]       w_in_head;

    logic [ENT_W-1:0]      r_out_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_out_wptr, r_out_rptr;
    logic [CW-1:0]         r_out_cnt;
    logic                  w_out_empty, w_out_nf, w_out_push, w_out_pop;
    logic [ENT_W-1:0]      w_out_head, w_out_ent;

    logic [CAP_W-1:0]      r_acc, w_acc_e, w_ins, w_ins_sh, w_acc_next;
    logic [6:0]            r_fill, w_fill_e, w_fill_next;
    logic                  w_fill_ge, w_emit, w_load;
    logic                  r_flush_pend, w_flush_done, w_tail_push;
    logic [5:0]            w_push_bytes;
    logic [OUT_W-1:0]      r_rd_data_p1;

    // Input FIFO: writes are refused when truly full so stored words are never overwritten
    assign w_in_empty = (r_in_cnt == '0);
    assign w_in_tfull = (r_in_cnt == DEPTH_C);
    assign w_in_push  = wr_en && !w_in_tfull;
    assign w_in_pop   = w_load;
    assign w_in_head  = r_in_mem[r_in_rptr];
    assign full       = (r_in_cnt >= NFULL_C);

    always_ff @(posedge clk) begin
        if (w_in_push) r_in_mem[r_in_wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_wptr <= '0;
            r_in_rptr <= '0;
            r_in_cnt  <= '0;
        end else begin
            if (w_in_push) r_in_wptr <= r_in_wptr + 1'b1;
            if (w_in_pop)  r_in_rptr <= r_in_rptr + 1'b1;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
                2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Accumulator: byte 0 sits at the MSB end; bytes below fill are kept zero
    assign w_fill_ge    = (r_fill >= OUT_C);
    assign w_emit       = w_fill_ge && !w_out_nf;
    assign w_fill_e     = w_emit ? (r_fill - OUT_C) : r_fill;
    assign w_load       = !w_in_empty && ((w_fill_e + IN_C) <= CAP_C);
    assign w_flush_done = r_flush_pend && w_in_empty && !w_fill_ge &&
                          ((r_fill == '0) || !w_out_nf);
    assign w_tail_push  = w_flush_done && (r_fill != '0);
    assign w_acc_e      = w_emit ? (r_acc << OUT_W) : r_acc;
    assign w_ins_sh     = w_ins >> {w_fill_e, 3'b000};
    assign w_push_bytes = w_emit ? OUT_B6 : r_fill[5:0];
    assign w_out_ent    = {w_push_bytes, r_acc[CAP_W-1 -: OUT_W]};

    always_comb begin
        w_ins = '0;
        w_ins[CAP_W-1 -: IN_W] = w_in_head;
    end

    always_comb begin
        w_acc_next  = w_acc_e;
        w_fill_next = w_fill_e;
        if (w_flush_done) begin
            w_acc_next  = '0;
            w_fill_next = '0;
        end else if (w_load) begin
            w_acc_next  = w_acc_e | w_ins_sh;
            w_fill_next = w_fill_e + IN_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_fill       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_acc  <= w_acc_next;
            r_fill <= w_fill_next;
            if (w_flush_done)
                r_flush_pend <= 1'b0;
            else if (flush && !r_flush_pend)
                r_flush_pend <= 1'b1;
        end
    end

    assign flush_busy = r_flush_pend;

    // Output FIFO: both full words and flush tails stop at nearly-full
    assign w_out_empty = (r_out_cnt == '0);
    assign w_out_nf    = (r_out_cnt >= NFULL_C);
    assign w_out_push  = w_emit || w_tail_push;
    assign w_out_pop   = rd_en && !w_out_empty;
    assign w_out_head  = r_out_mem[r_out_rptr];

    always_ff @(posedge clk) begin
        if (w_out_push) r_out_mem[r_out_wptr] <= w_out_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_wptr <= '0;
            r_out_rptr <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_out_push) r_out_wptr <= r_out_wptr + 1'b1;
            if (w_out_pop)  r_out_rptr <= r_out_rptr + 1'b1;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign empty    = w_out_empty;
    assign rd_data  = w_out_head[OUT_W-1:0];
    assign rd_bytes = w_out_head[ENT_W-1 -: 6];

    // Stage p1: registered copy of the output head
    always_ff @(posedge clk) begin
        if (rst) r_rd_data_p1 <= '0;
        else     r_rd_data_p1 <= rd_data;
    end

    assign rd_data_d1 = r_rd_data_p1;

`ifdef GEARBOX_ERR_CHECK_EN
    logic r_err_ovf, r_err_udf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (wr_en && w_in_tfull)  r_err_ovf <= 1'b1;
            if (rd_en && w_out_empty) r_err_udf <= 1'b1;
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule
